// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
// Taken control transfers raise a one-cycle redirect and squash the wrong-path slot behind them.
module ex_stage #(
    parameter int XLEN        = 32,
    parameter int PC_SIZE     = 32,
    parameter int RFIDX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [XLEN-1:0]        read_data1,
    input  logic [XLEN-1:0]        read_data2,
    input  logic [XLEN-1:0]        imm,
    input  logic [PC_SIZE-1:0]     bxx_imm,
    input  logic [3:0]             alu_funct,
    input  logic [RFIDX_WIDTH-1:0] rs1_index,
    input  logic [RFIDX_WIDTH-1:0] rs2_index,
    input  logic [RFIDX_WIDTH-1:0] rd_index,
    input  logic [PC_SIZE-1:0]     pc,
    input  logic [2:0]             m_mem_mode,
    input  logic                   ex_branch,
    input  logic                   ex_add2_sel,
    input  logic                   ex_pc_sel,
    input  logic [1:0]             ex_alu_op,
    input  logic                   m_mem_read,
    input  logic                   m_mem_write,
    input  logic                   wb_reg_write,
    input  logic                   wb_memtoreg,
    input  logic                   wb_fwd_we,
    input  logic [RFIDX_WIDTH-1:0] wb_fwd_index,
    input  logic [XLEN-1:0]        wb_fwd_data,
    input  logic                   mem_stall,
    output logic                   ex_ready,
    output logic                   ex_mem_valid,
    output logic [XLEN-1:0]        ex_mem_alu_result,
    output logic [XLEN-1:0]        ex_mem_store_data,
    output logic [RFIDX_WIDTH-1:0] ex_mem_rd_index,
    output logic [2:0]             ex_mem_mem_mode,
    output logic                   ex_mem_mem_read,
    output logic                   ex_mem_mem_write,
    output logic                   ex_mem_reg_write,
    output logic                   ex_mem_memtoreg,
    output logic                   redirect_valid,
    output logic [PC_SIZE-1:0]     redirect_pc
);

    logic            accept;
    logic            ex_fwd_ok;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [XLEN-1:0] op_b;
    logic [3:0]      alu_code;
    logic [XLEN-1:0] alu_result;
    logic [4:0]      shamt;
    logic            lt_signed;
    logic            lt_unsigned;
    logic            branch_cond;
    logic            taken;
    logic [XLEN-1:0]    jalr_sum;
    logic [PC_SIZE-1:0] pc_plus4;
    logic [PC_SIZE-1:0] target;
    logic [XLEN-1:0]    result;

    assign ex_ready  = ~mem_stall;
    assign accept    = in_valid & ~mem_stall & ~redirect_valid;
    assign ex_fwd_ok = ex_mem_valid & ex_mem_reg_write & ~ex_mem_memtoreg;

    // EX/MEM result has priority over the write-back port; x0 is never forwarded
    always_comb begin
        fwd_rs1 = read_data1;
        fwd_rs2 = read_data2;
        if (rs1_index != '0 && ex_fwd_ok && ex_mem_rd_index == rs1_index)
            fwd_rs1 = ex_mem_alu_result;
        else if (rs1_index != '0 && wb_fwd_we && wb_fwd_index == rs1_index)
            fwd_rs1 = wb_fwd_data;
        if (rs2_index != '0 && ex_fwd_ok && ex_mem_rd_index == rs2_index)
            fwd_rs2 = ex_mem_alu_result;
        else if (rs2_index != '0 && wb_fwd_we && wb_fwd_index == rs2_index)
            fwd_rs2 = wb_fwd_data;
    end

    assign op_b  = ex_add2_sel ? imm : fwd_rs2;
    assign shamt = op_b[4:0];

    // I-type ops carry immediate bits in funct[3], so it only matters for SRAI
    always_comb begin
        alu_code = 4'b0000;
        case (ex_alu_op)
            2'b00:   alu_code = 4'b0000;
            2'b01:   alu_code = 4'b1000;
            2'b10:   alu_code = alu_funct;
            default: alu_code = {(alu_funct[2:0] == 3'b101) & alu_funct[3], alu_funct[2:0]};
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alu_code[2:0])
            3'b000:  alu_result = alu_code[3] ? (fwd_rs1 - op_b) : (fwd_rs1 + op_b);
            3'b001:  alu_result = fwd_rs1 << shamt;
            3'b010:  alu_result = {{(XLEN-1){1'b0}}, $signed(fwd_rs1) < $signed(op_b)};
            3'b011:  alu_result = {{(XLEN-1){1'b0}}, fwd_rs1 < op_b};
            3'b100:  alu_result = fwd_rs1 ^ op_b;
            3'b101:  alu_result = alu_code[3] ? $unsigned($signed(fwd_rs1) >>> shamt)
                                              : (fwd_rs1 >> shamt);
            3'b110:  alu_result = fwd_rs1 | op_b;
            default: alu_result = fwd_rs1 & op_b;
        endcase
    end

    assign lt_signed   = $signed(fwd_rs1) < $signed(fwd_rs2);
    assign lt_unsigned = fwd_rs1 < fwd_rs2;

    always_comb begin
        branch_cond = 1'b0;
        case (alu_funct[2:0])
            3'b000:  branch_cond = (fwd_rs1 == fwd_rs2);
            3'b001:  branch_cond = (fwd_rs1 != fwd_rs2);
            3'b100:  branch_cond = lt_signed;
            3'b101:  branch_cond = ~lt_signed;
            3'b110:  branch_cond = lt_unsigned;
            3'b111:  branch_cond = ~lt_unsigned;
            default: branch_cond = 1'b0;
        endcase
    end

    assign taken    = ex_pc_sel | (ex_branch & branch_cond);
    assign jalr_sum = fwd_rs1 + imm;
    assign pc_plus4 = pc + PC_SIZE'(4);
    assign target   = (ex_pc_sel && ex_add2_sel) ? {jalr_sum[PC_SIZE-1:1], 1'b0}
                                                 : (pc + bxx_imm);
    assign result   = ex_pc_sel ? XLEN'(pc_plus4) : alu_result;

    // Stall freezes the pipeline register; a non-accepted slot becomes a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_valid      <= 1'b0;
            ex_mem_alu_result <= '0;
            ex_mem_store_data <= '0;
            ex_mem_rd_index   <= '0;
            ex_mem_mem_mode   <= '0;
            ex_mem_mem_read   <= 1'b0;
            ex_mem_mem_write  <= 1'b0;
            ex_mem_reg_write  <= 1'b0;
            ex_mem_memtoreg   <= 1'b0;
            redirect_valid    <= 1'b0;
            redirect_pc       <= '0;
        end else if (mem_stall) begin
            redirect_valid <= 1'b0;
        end else begin
            ex_mem_valid     <= accept;
            ex_mem_mem_read  <= accept & m_mem_read;
            ex_mem_mem_write <= accept & m_mem_write;
            ex_mem_reg_write <= accept & wb_reg_write & (rd_index != '0);
            ex_mem_memtoreg  <= accept & wb_memtoreg;
            ex_mem_mem_mode  <= accept ? m_mem_mode : 3'b000;
            redirect_valid   <= accept & taken;
            if (accept) begin
                ex_mem_alu_result <= result;
                ex_mem_store_data <= fwd_rs2;
                ex_mem_rd_index   <= rd_index;
            end
            if (accept && taken)
                redirect_pc <= target;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vector table plus forwarding, branch/jump, stall and reset sequences.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] read_data1, read_data2, imm, bxx_imm, pc;
    logic [3:0]  alu_funct;
    logic [4:0]  rs1_index, rs2_index, rd_index;
    logic [2:0]  m_mem_mode;
    logic        ex_branch, ex_add2_sel, ex_pc_sel;
    logic [1:0]  ex_alu_op;
    logic        m_mem_read, m_mem_write, wb_reg_write, wb_memtoreg;
    logic        wb_fwd_we;
    logic [4:0]  wb_fwd_index;
    logic [31:0] wb_fwd_data;
    logic        mem_stall;
    logic        ex_ready, ex_mem_valid;
    logic [31:0] ex_mem_alu_result, ex_mem_store_data;
    logic [4:0]  ex_mem_rd_index;
    logic [2:0]  ex_mem_mem_mode;
    logic        ex_mem_mem_read, ex_mem_mem_write, ex_mem_reg_write, ex_mem_memtoreg;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic [1:0]  alu_op;
        logic [3:0]  funct;
        logic        add2_sel;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm_v;
        logic [4:0]  rd;
        logic [31:0] exp_result;
        logic        exp_reg_write;
    } vec_t;

    vec_t vecs [16];

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .read_data1(read_data1), .read_data2(read_data2), .imm(imm), .bxx_imm(bxx_imm),
        .alu_funct(alu_funct), .rs1_index(rs1_index), .rs2_index(rs2_index), .rd_index(rd_index),
        .pc(pc), .m_mem_mode(m_mem_mode), .ex_branch(ex_branch), .ex_add2_sel(ex_add2_sel),
        .ex_pc_sel(ex_pc_sel), .ex_alu_op(ex_alu_op), .m_mem_read(m_mem_read),
        .m_mem_write(m_mem_write), .wb_reg_write(wb_reg_write), .wb_memtoreg(wb_memtoreg),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_index(wb_fwd_index), .wb_fwd_data(wb_fwd_data),
        .mem_stall(mem_stall), .ex_ready(ex_ready), .ex_mem_valid(ex_mem_valid),
        .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_store_data(ex_mem_store_data),
        .ex_mem_rd_index(ex_mem_rd_index), .ex_mem_mem_mode(ex_mem_mem_mode),
        .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_memtoreg(ex_mem_memtoreg),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        in_valid = 0; read_data1 = 0; read_data2 = 0; imm = 0; bxx_imm = 0; pc = 0;
        alu_funct = 0; rs1_index = 5'd1; rs2_index = 5'd2; rd_index = 0; m_mem_mode = 0;
        ex_branch = 0; ex_add2_sel = 0; ex_pc_sel = 0; ex_alu_op = 0;
        m_mem_read = 0; m_mem_write = 0; wb_reg_write = 0; wb_memtoreg = 0;
        wb_fwd_we = 0; wb_fwd_index = 0; wb_fwd_data = 0; mem_stall = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        clearInputs();
        in_valid = 1; wb_reg_write = 1;
        ex_alu_op = v.alu_op; alu_funct = v.funct; ex_add2_sel = v.add2_sel;
        read_data1 = v.rd1; read_data2 = v.rd2; imm = v.imm_v; rd_index = v.rd;
        step();
    endtask

    // Drives an ALU instruction without stepping the clock
    task automatic setAlu(input logic [1:0] op, input logic [3:0] fn, input logic sel,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] iv);
        clearInputs();
        in_valid = 1; wb_reg_write = 1; ex_alu_op = op; alu_funct = fn; ex_add2_sel = sel;
        rs1_index = rs1; rs2_index = rs2; rd_index = rd;
        read_data1 = d1; read_data2 = d2; imm = iv;
    endtask

    task automatic setBranch(input logic [2:0] cond, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] bpc,
                             input logic [31:0] off);
        clearInputs();
        in_valid = 1; ex_branch = 1; ex_alu_op = 2'b01; alu_funct = {1'b0, cond};
        read_data1 = d1; read_data2 = d2; pc = bpc; bxx_imm = off;
    endtask

    initial begin
        vecs[0]  = '{2'b11, 4'b0000, 1'b1, 32'h7FFFFFFF, 32'h0,        32'h1,  5'd5,  32'h80000000, 1'b1};
        vecs[1]  = '{2'b10, 4'b1101, 1'b0, 32'h80000010, 32'h4,        32'h0,  5'd6,  32'hF8000001, 1'b1};
        vecs[2]  = '{2'b10, 4'b0101, 1'b0, 32'h80000010, 32'h4,        32'h0,  5'd7,  32'h08000001, 1'b1};
        vecs[3]  = '{2'b11, 4'b1101, 1'b1, 32'h80000010, 32'h0,        32'h4,  5'd8,  32'hF8000001, 1'b1};
        vecs[4]  = '{2'b11, 4'b1000, 1'b1, 32'h00000010, 32'h0,        32'h3,  5'd9,  32'h00000013, 1'b1};
        vecs[5]  = '{2'b10, 4'b1000, 1'b0, 32'h00000005, 32'h7,        32'h0,  5'd10, 32'hFFFFFFFE, 1'b1};
        vecs[6]  = '{2'b10, 4'b0010, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,  5'd11, 32'h00000001, 1'b1};
        vecs[7]  = '{2'b10, 4'b0011, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,  5'd12, 32'h00000000, 1'b1};
        vecs[8]  = '{2'b10, 4'b0100, 1'b0, 32'hA5A5A5A5, 32'hFFFF0000, 32'h0,  5'd13, 32'h5A5AA5A5, 1'b1};
        vecs[9]  = '{2'b10, 4'b0110, 1'b0, 32'hF0F00000, 32'h00000F0F, 32'h0,  5'd14, 32'hF0F00F0F, 1'b1};
        vecs[10] = '{2'b10, 4'b0111, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0,  5'd15, 32'h0F000F00, 1'b1};
        vecs[11] = '{2'b10, 4'b0001, 1'b0, 32'h00000001, 32'h00000021, 32'h0,  5'd16, 32'h00000002, 1'b1};
        vecs[12] = '{2'b00, 4'b0111, 1'b1, 32'h00000100, 32'h0,  32'hFFFFFFFC, 5'd17, 32'h000000FC, 1'b1};
        vecs[13] = '{2'b01, 4'b0000, 1'b0, 32'h00000000, 32'h1,        32'h0,  5'd18, 32'hFFFFFFFF, 1'b1};
        vecs[14] = '{2'b11, 4'b0000, 1'b1, 32'h00000004, 32'h0,        32'h5,  5'd0,  32'h00000009, 1'b0};
        vecs[15] = '{2'b11, 4'b0011, 1'b1, 32'h00000004, 32'h0,        32'h5,  5'd19, 32'h00000001, 1'b1};

        clearInputs();
        rst_n = 0;
        #1;
        checkOutput("reset valid", 32'(ex_mem_valid), 32'h0);
        checkOutput("reset result", ex_mem_alu_result, 32'h0);
        checkOutput("reset store_data", ex_mem_store_data, 32'h0);
        checkOutput("reset redirect_valid", 32'(redirect_valid), 32'h0);
        checkOutput("reset redirect_pc", redirect_pc, 32'h0);
        checkOutput("reset reg_write", 32'(ex_mem_reg_write), 32'h0);
        checkOutput("ex_ready idle", 32'(ex_ready), 32'h1);
        #12 rst_n = 1;
        step();

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d result", i), ex_mem_alu_result, vecs[i].exp_result);
            checkOutput($sformatf("vec%0d reg_write", i), 32'(ex_mem_reg_write), 32'(vecs[i].exp_reg_write));
            checkOutput($sformatf("vec%0d valid", i), 32'(ex_mem_valid), 32'h1);
            checkOutput($sformatf("vec%0d rd", i), 32'(ex_mem_rd_index), 32'(vecs[i].rd));
        end

        // Forwarding: ADD x3; SUB x4,x3,x1 picks EX/MEM over a competing wb write of x3
        setAlu(2'b10, 4'b0000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h10, 32'h20, 32'h0);
        step();
        checkOutput("fwd add x3", ex_mem_alu_result, 32'h30);
        setAlu(2'b10, 4'b1000, 1'b0, 5'd3, 5'd1, 5'd4, 32'hDEAD, 32'h10, 32'h0);
        wb_fwd_we = 1; wb_fwd_index = 5'd3; wb_fwd_data = 32'h11;
        step();
        checkOutput("fwd sub exmem", ex_mem_alu_result, 32'h20);
        checkOutput("fwd store_data", ex_mem_store_data, 32'h10);
        setAlu(2'b10, 4'b0000, 1'b0, 5'd3, 5'd2, 5'd6, 32'hDEAD, 32'h1, 32'h0);
        wb_fwd_we = 1; wb_fwd_index = 5'd3; wb_fwd_data = 32'h11;
        step();
        checkOutput("fwd wb", ex_mem_alu_result, 32'h12);
        setAlu(2'b10, 4'b0000, 1'b0, 5'd1, 5'd2, 5'd0, 32'h10, 32'h20, 32'h0);
        step();
        checkOutput("rd0 reg_write", 32'(ex_mem_reg_write), 32'h0);
        setAlu(2'b10, 4'b0000, 1'b0, 5'd0, 5'd2, 5'd7, 32'h5, 32'h1, 32'h0);
        wb_fwd_we = 1; wb_fwd_index = 5'd0; wb_fwd_data = 32'h99;
        step();
        checkOutput("rd0 no fwd", ex_mem_alu_result, 32'h6);

        // BNE taken, then a taken wrong-path store-flagged branch must be squashed
        setBranch(3'b001, 32'h1, 32'h2, 32'h100, 32'h20);
        step();
        checkOutput("bne redirect_valid", 32'(redirect_valid), 32'h1);
        checkOutput("bne redirect_pc", redirect_pc, 32'h120);
        checkOutput("bne valid", 32'(ex_mem_valid), 32'h1);
        setBranch(3'b001, 32'h1, 32'h2, 32'h104, 32'h40);
        m_mem_write = 1;
        step();
        checkOutput("squash valid", 32'(ex_mem_valid), 32'h0);
        checkOutput("squash mem_write", 32'(ex_mem_mem_write), 32'h0);
        checkOutput("squash redirect", 32'(redirect_valid), 32'h0);
        checkOutput("squash redirect_pc", redirect_pc, 32'h120);
        setBranch(3'b000, 32'h1, 32'h2, 32'h108, 32'h20);
        step();
        checkOutput("beq not taken", 32'(redirect_valid), 32'h0);
        checkOutput("beq valid", 32'(ex_mem_valid), 32'h1);
        setBranch(3'b100, 32'hFFFFFFFF, 32'h1, 32'h200, 32'hFFFFFFF0);
        step();
        checkOutput("blt taken", 32'(redirect_valid), 32'h1);
        checkOutput("blt target", redirect_pc, 32'h1F0);
        clearInputs();
        step();
        checkOutput("blt pulse clears", 32'(redirect_valid), 32'h0);
        setBranch(3'b110, 32'hFFFFFFFF, 32'h1, 32'h300, 32'h8);
        step();
        checkOutput("bltu not taken", 32'(redirect_valid), 32'h0);
        setBranch(3'b010, 32'h1, 32'h1, 32'h300, 32'h8);
        step();
        checkOutput("cond010 never", 32'(redirect_valid), 32'h0);
        setBranch(3'b111, 32'hFFFFFFFF, 32'h1, 32'h300, 32'h4);
        step();
        checkOutput("bgeu taken", 32'(redirect_valid), 32'h1);
        checkOutput("bgeu target", redirect_pc, 32'h304);
        clearInputs();
        step();

        // JALR clears bit 0 of the target and writes pc+4
        setAlu(2'b00, 4'b0000, 1'b1, 5'd1, 5'd0, 5'd1, 32'h1003, 32'h0, 32'h0);
        ex_pc_sel = 1; pc = 32'h40;
        step();
        checkOutput("jalr redirect", 32'(redirect_valid), 32'h1);
        checkOutput("jalr target", redirect_pc, 32'h1002);
        checkOutput("jalr result", ex_mem_alu_result, 32'h44);
        checkOutput("jalr reg_write", 32'(ex_mem_reg_write), 32'h1);
        clearInputs();
        step();
        setAlu(2'b00, 4'b0000, 1'b0, 5'd0, 5'd0, 5'd1, 32'h1003, 32'h0, 32'h0);
        ex_pc_sel = 1; pc = 32'h40; bxx_imm = 32'h80;
        step();
        checkOutput("jal target", redirect_pc, 32'hC0);
        checkOutput("jal result", ex_mem_alu_result, 32'h44);
        clearInputs();
        step();

        // Stall for three cycles holds the register, release accepts the waiting op
        setAlu(2'b11, 4'b0000, 1'b1, 5'd1, 5'd0, 5'd8, 32'h1000, 32'h0, 32'h23);
        step();
        checkOutput("pre-stall result", ex_mem_alu_result, 32'h1023);
        setAlu(2'b11, 4'b0000, 1'b1, 5'd1, 5'd0, 5'd9, 32'h2000, 32'h0, 32'h1);
        mem_stall = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput($sformatf("stall%0d result", c), ex_mem_alu_result, 32'h1023);
            checkOutput($sformatf("stall%0d rd", c), 32'(ex_mem_rd_index), 32'd8);
            checkOutput($sformatf("stall%0d valid", c), 32'(ex_mem_valid), 32'h1);
            checkOutput($sformatf("stall%0d ex_ready", c), 32'(ex_ready), 32'h0);
        end
        mem_stall = 0;
        step();
        checkOutput("release result", ex_mem_alu_result, 32'h2001);
        checkOutput("release rd", 32'(ex_mem_rd_index), 32'd9);

        // Reset in the middle of a stall clears everything without a clock edge
        mem_stall = 1;
        step();
        rst_n = 0;
        #1;
        checkOutput("midrst valid", 32'(ex_mem_valid), 32'h0);
        checkOutput("midrst result", ex_mem_alu_result, 32'h0);
        checkOutput("midrst store_data", ex_mem_store_data, 32'h0);
        checkOutput("midrst rd", 32'(ex_mem_rd_index), 32'h0);
        checkOutput("midrst reg_write", 32'(ex_mem_reg_write), 32'h0);
        checkOutput("midrst redirect_pc", redirect_pc, 32'h0);
        #2;
        rst_n = 1;
        setAlu(2'b11, 4'b0000, 1'b1, 5'd1, 5'd0, 5'd10, 32'h5, 32'h0, 32'h5);
        step();
        checkOutput("post-rst valid", 32'(ex_mem_valid), 32'h1);
        checkOutput("post-rst result", ex_mem_alu_result, 32'hA);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the in-order RISC-V integer pipeline. It consumes operands, immediates and control bits from the ID/EX pipeline register, and resolves operand forwarding, ALU operations, branches and jumps. Results go into an internal EX/MEM pipeline register that feeds the memory stage. It also produces a one-cycle front-end redirect for taken control transfers and squashes the wrong-path instruction behind them.

## Interface
- XLEN, 32, datapath width
- PC_SIZE, 32, program counter width
- RFIDX_WIDTH, 5, register index width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID/EX holds a valid instruction
- read_data1, read_data2  in  XLEN  register file operands
- imm  in  XLEN  ALU immediate
- bxx_imm  in  PC_SIZE  branch/jump offset
- alu_funct  in  4  {funct7[5], funct3}
- rs1_index, rs2_index, rd_index  in  RFIDX_WIDTH  register indices
- pc  in  PC_SIZE  instruction PC
- m_mem_mode  in  3  load/store size/sign, passed through
- ex_branch, ex_add2_sel, ex_pc_sel  in  1  branch, operand-B select (1=imm), unconditional jump
- ex_alu_op  in  2  ALU op class
- m_mem_read, m_mem_write, wb_reg_write, wb_memtoreg  in  1  downstream controls
- wb_fwd_we  in  1  write-back stage writes register
- wb_fwd_index  in  RFIDX_WIDTH  write-back destination
- wb_fwd_data  in  XLEN  write-back data
- mem_stall  in  1  memory stage cannot accept
- ex_ready  out  1  equals ~mem_stall
- ex_mem_valid  out  1  registered valid
- ex_mem_alu_result, ex_mem_store_data  out  XLEN  registered result / forwarded rs2
- ex_mem_rd_index  out  RFIDX_WIDTH
- ex_mem_mem_mode  out  3
- ex_mem_mem_read, ex_mem_mem_write, ex_mem_reg_write, ex_mem_memtoreg  out  1
- redirect_valid  out  1  registered one-cycle redirect pulse
- redirect_pc  out  PC_SIZE  redirect target

## Operation
- Accept condition: in_valid & ~mem_stall & ~redirect_valid.
- When redirect_valid=1, the instruction currently at the inputs is wrong-path. It is squashed: it produces no valid output and no redirect.
- Forwarding, per source operand, rs==0 never forwarded:
  - Priority 1: EX/MEM output if ex_mem_valid & ex_mem_reg_write & ~ex_mem_memtoreg & index match → ex_mem_alu_result.
  - Priority 2: wb_fwd_we & wb_fwd_index match → wb_fwd_data.
  - Otherwise: read_data.
  - Load-use stalls are upstream's responsibility.
- Operand B = ex_add2_sel ? imm : fwd rs2. Store data is always fwd rs2.
- ex_alu_op:
  - 00: ADD (address calculation).
  - 01: SUB (compare).
  - 10: R-type, decoded by alu_funct.
  - 11: I-type, decoded by alu_funct with bit3 honoured only for shift-right.
- alu_funct codes: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
- Shift amount is operand B [4:0]. All arithmetic is modulo 2^XLEN.
- Branch (ex_branch=1): alu_funct[2:0] selects the condition. 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 never taken. Target = pc + bxx_imm.
- Jump (ex_pc_sel=1): always taken.
  - Target = ex_add2_sel ? (fwd rs1 + imm) & ~1 : pc + bxx_imm.
  - Result = pc + 4.
- ex_mem_reg_write is forced 0 when rd_index==0.
- Non-accepted, non-stalled cycles load a bubble: valid=0 and all control outputs 0. Data outputs are don't-care but held.

## Timing
- Reset (async, rst_n=0): every output register is 0, including redirect_pc and all data outputs.
- Latency: 1 cycle, input to ex_mem_* outputs.
- mem_stall=1: all ex_mem_* registers hold. No acceptance occurs and redirect_valid clears to 0.
- redirect_valid/redirect_pc:
  - Registered on the acceptance edge of a taken branch or jump, so they appear together with that instruction's ex_mem outputs.
  - redirect_valid is high for exactly one cycle.
- Back-to-back taken branches: the second is the squashed slot and is never redirected.
- Reset asserted mid-stall clears state immediately. The first acceptance is possible on the first edge after rst_n rises.

## Test plan
- ADDI x5 with read_data1=0x7FFFFFFF, imm=1 → next cycle ex_mem_alu_result=0x80000000, reg_write=1, rd=5.
- SRA with rs1=0x80000010 and operand B=4 → 0xF8000001. SRL with the same operands → 0x08000001.
- Forwarding: ADD x3, then SUB x4,x3,x1 issued immediately after, while wb writes x3=0x11. SUB must use the EX/MEM value, not 0x11. With rd=0, no forwarding occurs.
- BNE taken at pc=0x100, bxx_imm=0x20 → redirect_valid one cycle, redirect_pc=0x120. The following in_valid instruction is squashed (ex_mem_valid=0, mem_write=0).
- JALR at pc=0x40 with rs1=0x1003, imm=0 → redirect_pc=0x1002, result=0x44.
- Hold mem_stall for 3 cycles with in_valid=1 → outputs frozen and ex_ready=0. Releasing the stall accepts the instruction. Asserting rst_n=0 mid-stall zeroes all outputs immediately.
